// File: rtl/ddr_port_arbiter.sv
// Two-port round-robin arbiter in front of an SDRAM controller, with periodic refresh requests.
// Optional DDR_ARB_STATS_EN adds saturating grant/refresh counters.
module ddr_port_arbiter #(
  parameter int unsigned AddrWidth     = 23,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned RefreshPeriod = 780
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             req,
  input  logic [1:0]             write,
  input  logic [2*AddrWidth-1:0] addr,
  input  logic [2*DataWidth-1:0] wdata,
  output logic [1:0]             grant,
  output logic [1:0]             rvalid,
  output logic [DataWidth-1:0]   rdata,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_write,
  output logic [AddrWidth-1:0]   cmd_addr,
  output logic [DataWidth-1:0]   cmd_wdata,
  input  logic                   rsp_valid,
  input  logic [DataWidth-1:0]   rsp_data,
  output logic                   ref_req,
  input  logic                   ref_ack,
  output logic                   busy
`ifdef DDR_ARB_STATS_EN
  ,
  output logic [15:0]            stat_grant0,
  output logic [15:0]            stat_grant1,
  output logic [15:0]            stat_refresh
`endif
);

  localparam int unsigned CntW = (RefreshPeriod > 2) ? $clog2(RefreshPeriod) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(RefreshPeriod - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWait,
    StRefresh
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   expire;
  logic                   ref_pend_q;
  logic                   last_q;
  logic                   sel_q;
  logic                   sel;
  logic [1:0]             grant_q;
  logic [1:0]             rvalid_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   cmd_valid_q;
  logic                   cmd_write_q;
  logic [AddrWidth-1:0]   cmd_addr_q;
  logic [DataWidth-1:0]   cmd_wdata_q;
  logic                   ref_req_q;
  logic                   busy_q;

  // Refresh timer runs freely in every state.
  always_comb begin
    expire = (cnt_q == '0);
    cnt_d  = expire ? CntReload : cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= CntReload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With both ports requesting, serve the one that was not served last.
  always_comb begin
    sel = 1'b0;
    unique case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_q;
      default: sel = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ref_pend_q  <= 1'b0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      grant_q     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ref_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      grant_q  <= '0;
      rvalid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (ref_pend_q) begin
            state_q   <= StRefresh;
            ref_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (req != 2'b00) begin
            state_q          <= StCmd;
            sel_q            <= sel;
            last_q           <= sel;
            grant_q[sel]     <= 1'b1;
            cmd_valid_q      <= 1'b1;
            cmd_write_q      <= write[sel];
            cmd_addr_q       <= sel ? addr[2*AddrWidth-1:AddrWidth] : addr[AddrWidth-1:0];
            cmd_wdata_q      <= sel ? wdata[2*DataWidth-1:DataWidth] : wdata[DataWidth-1:0];
            busy_q           <= 1'b1;
          end
        end
        StCmd: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (rsp_valid) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (!cmd_write_q) begin
              rdata_q         <= rsp_data;
              rvalid_q[sel_q] <= 1'b1;
            end
          end
        end
        StRefresh: begin
          if (ref_ack) begin
            ref_req_q  <= 1'b0;
            ref_pend_q <= 1'b0;
            state_q    <= StIdle;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
      // A fresh expiry on the acknowledge edge must not be lost.
      if (expire) begin
        ref_pend_q <= 1'b1;
      end
    end
  end

  assign grant     = grant_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign ref_req   = ref_req_q;
  assign busy      = busy_q;

`ifdef DDR_ARB_STATS_EN
  logic [15:0] stat_g0_q, stat_g1_q, stat_ref_q;
  logic        ref_hs;

  assign ref_hs = (state_q == StRefresh) && ref_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_g0_q  <= '0;
      stat_g1_q  <= '0;
      stat_ref_q <= '0;
    end else begin
      if (grant_q[0] && (stat_g0_q != 16'hFFFF)) begin
        stat_g0_q <= stat_g0_q + 16'd1;
      end
      if (grant_q[1] && (stat_g1_q != 16'hFFFF)) begin
        stat_g1_q <= stat_g1_q + 16'd1;
      end
      if (ref_hs && (stat_ref_q != 16'hFFFF)) begin
        stat_ref_q <= stat_ref_q + 16'd1;
      end
    end
  end

  assign stat_grant0  = stat_g0_q;
  assign stat_grant1  = stat_g1_q;
  assign stat_refresh = stat_ref_q;
`endif

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed self-checking bench for ddr_port_arbiter with RefreshPeriod = 16.
module tb_ddr_port_arbiter;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      req;
  logic [1:0]      write;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      grant;
  logic [1:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            ref_req;
  logic            ref_ack;
  logic            busy;

  int checks = 0;
  int errors = 0;

  ddr_port_arbiter #(
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .RefreshPeriod(16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .grant    (grant),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .ref_req  (ref_req),
    .ref_ack  (ref_ack),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves reset released just after a rising edge; the next edge is edge 1.
  task automatic do_reset();
    reset     = 1'b0;
    req       = '0;
    write     = '0;
    addr      = '0;
    wdata     = '0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    ref_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '0; write = '0; addr = '0; wdata = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; ref_ack = 1'b0;
    tick();
    tick();
    checks++;
    if ({grant, rvalid, cmd_valid, cmd_write, ref_req, busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {grant, rvalid, cmd_valid, cmd_write, ref_req, busy});
    end
    checks++;
    if ({rdata, cmd_addr, cmd_wdata} !== {(2*DW+AW){1'b0}}) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0", rdata, cmd_addr,
               cmd_wdata);
    end
    reset = 1'b1;
  endtask

  task automatic test_refresh_idle();
    int early;
    do_reset();
    early = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ref_req !== 1'b0) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL refidle_early: ref_req high %0d cycles want 0", early);
    end
    req = 2'b11;
    tick(); // edge 17: refresh beats simultaneous requests
    checks++;
    if ({ref_req, grant, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL refidle_wins: got ref_req,grant,busy=%b want 1001", {ref_req, grant, busy});
    end
    ref_ack = 1'b1;
    tick();
    ref_ack = 1'b0;
    checks++;
    if ({ref_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL refidle_ack: got ref_req,busy=%b want 00", {ref_req, busy});
    end
    tick();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL refidle_grant: got %b want 01", grant);
    end
    req = '0;
  endtask

  task automatic test_read();
    int gcnt;
    do_reset();
    req = 2'b01; write = 2'b00; addr[AW-1:0] = 23'h000123; cmd_ready = 1'b1;
    tick(); // edge 1
    checks++;
    if ({grant, cmd_valid, cmd_write, busy} !== 5'b01101) begin
      errors++;
      $display("FAIL read_grant: got grant,cv,cw,busy=%b want 01101",
               {grant, cmd_valid, cmd_write, busy});
    end
    checks++;
    if (cmd_addr !== 23'h000123) begin
      errors++;
      $display("FAIL read_addr: got %h want 000123", cmd_addr);
    end
    req = '0;
    gcnt = 0;
    tick(); // edge 2
    if (grant != 0) gcnt++;
    checks++;
    if ({cmd_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL read_accept: got cv,busy=%b want 01", {cmd_valid, busy});
    end
    tick();
    if (grant != 0) gcnt++;
    tick();
    if (grant != 0) gcnt++;
    checks++;
    if (rvalid !== 2'b00) begin
      errors++;
      $display("FAIL read_early_rvalid: got %b want 00", rvalid);
    end
    rsp_valid = 1'b1; rsp_data = 32'hDEADBEEF;
    tick(); // edge 5
    if (grant != 0) gcnt++;
    rsp_valid = 1'b0;
    checks++;
    if ({rvalid, busy} !== 3'b010 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_rvalid: got rvalid,busy=%b rdata=%h want 010 deadbeef",
               {rvalid, busy}, rdata);
    end
    tick();
    if (grant != 0) gcnt++;
    checks++;
    if (rvalid !== 2'b00 || gcnt !== 0) begin
      errors++;
      $display("FAIL read_pulses: got rvalid=%b extra grants=%0d want 00 0", rvalid, gcnt);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g [4];
    logic [1:0] exp_r [4];
    int ng;
    int nr;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_r = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 2'b11; write = 2'b00; cmd_ready = 1'b1;
    rsp_valid = 1'b1; rsp_data = 32'h1111_0000; // held high: ignored outside WAIT
    ng = 0;
    nr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (grant != 2'b00) begin
        if (ng < 4) begin
          checks++;
          if (grant !== exp_g[ng]) begin
            errors++;
            $display("FAIL alt_grant%0d: got %b want %b", ng, grant, exp_g[ng]);
          end
        end
        ng++;
      end
      if (rvalid != 2'b00) begin
        if (nr < 4) begin
          checks++;
          if (rvalid !== exp_r[nr]) begin
            errors++;
            $display("FAIL alt_rvalid%0d: got %b want %b", nr, rvalid, exp_r[nr]);
          end
        end
        nr++;
      end
    end
    checks++;
    if (ng !== 4 || nr !== 4) begin
      errors++;
      $display("FAIL alt_count: got grants=%0d rvalids=%0d want 4 4", ng, nr);
    end
    req = '0; rsp_valid = 1'b0;
  endtask

  task automatic test_write_stall();
    int gcnt;
    int unstable;
    do_reset();
    req = 2'b10; write = 2'b10; addr[2*AW-1:AW] = 23'h0ABCDE;
    wdata[2*DW-1:DW] = 32'hCAFEF00D; cmd_ready = 1'b0;
    tick(); // edge 1
    gcnt = (grant != 0) ? 1 : 0;
    checks++;
    if (grant !== 2'b10 || {cmd_valid, cmd_write, cmd_addr, cmd_wdata} !==
        {1'b1, 1'b1, 23'h0ABCDE, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL wr_grant: got grant=%b cv=%b cw=%b a=%h d=%h want 10 1 1 0abcde cafef00d",
               grant, cmd_valid, cmd_write, cmd_addr, cmd_wdata);
    end
    req = '0; wdata = '0; addr = '0;
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (grant != 0) gcnt++;
      if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata} !==
          {1'b1, 1'b1, 23'h0ABCDE, 32'hCAFEF00D}) unstable++;
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL wr_stable: got %0d unstable cycles want 0", unstable);
    end
    cmd_ready = 1'b1;
    tick(); // edge 7
    cmd_ready = 1'b0;
    if (grant != 0) gcnt++;
    checks++;
    if ({cmd_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL wr_accept: got cv,busy=%b want 01", {cmd_valid, busy});
    end
    rsp_valid = 1'b1; rsp_data = 32'h5555AAAA;
    tick(); // edge 8
    rsp_valid = 1'b0;
    if (grant != 0) gcnt++;
    checks++;
    if ({rvalid, busy} !== 3'b000 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_no_rvalid: got rvalid,busy=%b rdata=%h want 000 0", {rvalid, busy},
               rdata);
    end
    tick();
    if (grant != 0) gcnt++;
    checks++;
    if (rvalid !== 2'b00 || gcnt !== 1) begin
      errors++;
      $display("FAIL wr_once: got rvalid=%b grants=%0d want 00 1", rvalid, gcnt);
    end
  endtask

  task automatic test_refresh_in_wait();
    do_reset();
    req = 2'b01; write = 2'b00; addr[AW-1:0] = 23'h000456; cmd_ready = 1'b1;
    tick(); // edge 1
    req = '0;
    tick(); // edge 2 -> WAIT
    cmd_ready = 1'b0;
    for (int i = 3; i <= 16; i++) tick();
    checks++;
    if ({ref_req, busy} !== 2'b01) begin
      errors++;
      $display("FAIL rw_hold: got ref_req,busy=%b want 01", {ref_req, busy});
    end
    req = 2'b10; addr[2*AW-1:AW] = 23'h000777;
    rsp_valid = 1'b1; rsp_data = 32'h12345678;
    tick(); // edge 17 -> IDLE
    rsp_valid = 1'b0;
    checks++;
    if ({rvalid, ref_req, grant, busy} !== 6'b010000 || rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rw_return: got rvalid,ref,grant,busy=%b rdata=%h want 010000 12345678",
               {rvalid, ref_req, grant, busy}, rdata);
    end
    tick(); // edge 18
    checks++;
    if ({ref_req, grant, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL rw_refresh: got ref,grant,busy=%b want 1001", {ref_req, grant, busy});
    end
    tick(); // edge 19, no ack yet
    checks++;
    if (ref_req !== 1'b1) begin
      errors++;
      $display("FAIL rw_ref_hold: got %b want 1", ref_req);
    end
    ref_ack = 1'b1;
    tick(); // edge 20
    ref_ack = 1'b0;
    checks++;
    if ({ref_req, grant, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rw_ack: got ref,grant,busy=%b want 0000", {ref_req, grant, busy});
    end
    tick(); // edge 21
    checks++;
    if (grant !== 2'b10 || cmd_addr !== 23'h000777) begin
      errors++;
      $display("FAIL rw_grant_after: got grant=%b addr=%h want 10 000777", grant, cmd_addr);
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b10; write = 2'b00; cmd_ready = 1'b0;
    tick(); // edge 1
    req = '0;
    tick(); // edge 2, still in CMD
    checks++;
    if ({cmd_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid_cmd: got cv,busy=%b want 11", {cmd_valid, busy});
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, busy, grant, rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async: got cv,busy,grant,rvalid=%b want 000000",
               {cmd_valid, busy, grant, rvalid});
    end
    tick();
    reset = 1'b1;
    req = 2'b11;
    tick();
    checks++;
    if (grant !== 2'b01 || rvalid !== 2'b00) begin
      errors++;
      $display("FAIL mid_port0: got grant=%b rvalid=%b want 01 00", grant, rvalid);
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_refresh_idle();
    test_read();
    test_alternate();
    test_write_stall();
    test_refresh_in_wait();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- AddrWidth, 23, requester and command address width.
- DataWidth, 32, read/write data width.
- RefreshPeriod, 780, cycles between refresh requests (7.8 us at 100 MHz).

REQ-002 Ports, one per line: name, direction, width, meaning. One clock; reset is asynchronous and active-low.
- clock, in, 1, sole clock; all state on its rising edge.
- reset, in, 1, asynchronous active-low reset.
- req, in, 2, per-port request; bit i is port i.
- write, in, 2, per-port direction (1 write, 0 read).
- addr, in, 2*AddrWidth, per-port address; port i at [i*AddrWidth +: AddrWidth].
- wdata, in, 2*DataWidth, per-port write data, packed as addr.
- grant, out, 2, one-cycle pulse: port i request captured.
- rvalid, out, 2, one-cycle pulse: rdata valid for port i.
- rdata, out, DataWidth, shared read data register.
- cmd_valid, out, 1, command to SDRAM controller valid.
- cmd_ready, in, 1, controller accepts command.
- cmd_write, out, 1, command direction.
- cmd_addr, out, AddrWidth, command address.
- cmd_wdata, out, DataWidth, command write data.
- rsp_valid, in, 1, controller completion pulse (reads and writes).
- rsp_data, in, DataWidth, read data, valid with rsp_valid.
- ref_req, out, 1, refresh request to controller.
- ref_ack, in, 1, refresh accepted.
- busy, out, 1, high when FSM is not IDLE.

Function
REQ-003 FSM states: IDLE, CMD, WAIT, REFRESH; all outputs registered.
REQ-004 Refresh counter decrements each cycle and reloads RefreshPeriod-1 after 0; reaching 0 sets ref_pending; a second expiry while pending leaves it set.
REQ-005 IDLE: ref_pending -> REFRESH, ref_req=1; refresh wins over simultaneous requests.
REQ-006 IDLE, no refresh pending, req!=0: select port, capture write/addr/wdata into cmd_*, pulse grant[sel] for one cycle, cmd_valid=1, -> CMD; grant and cmd_valid appear one cycle after req is sampled.
REQ-007 Arbitration: single requester wins; with both requesting, the port other than last-served wins; last-served updates on grant.
REQ-008 CMD: cmd_* held stable until cmd_valid & cmd_ready; that edge drops cmd_valid, -> WAIT.
REQ-009 WAIT: rsp_valid -> IDLE; for reads, rdata<=rsp_data and rvalid[sel] pulses one cycle; writes produce no rvalid.
REQ-010 REFRESH: ref_req held until ref_ack; that edge clears ref_pending, drops ref_req, -> IDLE.
REQ-011 rsp_valid outside WAIT and ref_ack outside REFRESH are ignored.
REQ-012 Requesters hold req/write/addr/wdata until grant; after grant, req may drop or stay (a held req is a new request).
REQ-013 One transaction outstanding at a time; refresh counter keeps running in every state.

Reset
REQ-014 reset low asynchronously forces IDLE, all outputs 0, ref_pending 0, last-served=1 (port 0 first), counter=RefreshPeriod-1; mid-transaction reset abandons it with no grant or rvalid.

Configuration
REQ-015 Macro DDR_ARB_STATS_EN: when defined, adds outputs stat_grant0, stat_grant1, stat_refresh (16 bits each, saturating at 0xFFFF, reset 0), counting grant[0], grant[1] and ref_ack handshakes; when undefined, these ports and counters are absent and behaviour is otherwise identical.

Verification (RefreshPeriod=16)
REQ-016 Port 0 read, addr 0x000123, cmd_ready=1, rsp after 3 cycles with 0xDEADBEEF -> grant=01 once, cmd_addr=0x000123, rvalid=01 with rdata=0xDEADBEEF.
REQ-017 Both ports continuously request reads -> grants alternate 01,10,01,10 starting with port 0.
REQ-018 Port 1 write 0xCAFEF00D, cmd_ready low 5 cycles -> cmd_* stable 5 cycles, one grant, no rvalid after rsp_valid.
REQ-019 Counter expires during WAIT -> ref_req rises the cycle after return to IDLE, before a pending req; ref_ack pulse clears it.
REQ-020 reset low during CMD -> cmd_valid=0 and busy=0 immediately; after release port 0 wins a simultaneous request.
